// File: rtl/pifo_pkg.sv
// Shared widths, the empty-pop sentinel and the arbitration pointer type
// for the PIFO access controller.
package pifo_pkg;

  localparam int PTW_DEF = 12;
  localparam int MTW_DEF = 8;
  localparam int ENTRY_W = MTW_DEF + PTW_DEF;

  // The tree answers a pop on an empty tree with all-ones.
  localparam logic [ENTRY_W-1:0] EMPTY_SENTINEL = '1;

  // Which side wins the next push/pop contention.
  typedef enum logic {
    PRIO_PUSH = 1'b0,
    PRIO_POP  = 1'b1
  } prio_e;

  // Width of a counter that must hold 0..cap inclusive.
  function automatic int clog2_cap(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/pifo_out_fifo.sv
// First-word-fall-through output buffer. The count output feeds the pop
// credit check in the controller.
module pifo_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic                       o_empty,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             rd_ok;
  logic             wr_ok;

  // A write at full is allowed only alongside a read that frees the slot.
  always_comb begin
    rd_ok = i_rd_en && (count != '0);
    wr_ok = i_wr_en && ((count != CW'(DEPTH)) || rd_ok);
  end

  // Pointer and fill-level bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = mem[rd_ptr];
  assign o_empty   = (count == '0);
  assign o_count   = count;

endmodule

// File: rtl/pifo_access_ctrl.sv
// Serialises pushes and pops into the PIFO tree with a minimum operation
// spacing, tracks tree occupancy, issues pops against output-buffer credit
// and forwards popped entries through a FWFT buffer.
module pifo_access_ctrl
  import pifo_pkg::*;
#(
  parameter int PTW        = PTW_DEF,
  parameter int MTW        = MTW_DEF,
  parameter int CAPACITY   = 14,
  parameter int OP_GAP     = 2,
  parameter int POP_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_enq_valid,
  input  logic [MTW+PTW-1:0]                i_enq_data,
  output logic                              o_enq_ready,
  output logic                              o_pifo_push,
  output logic [MTW+PTW-1:0]                o_pifo_push_data,
  output logic                              o_pifo_pop,
  input  logic [MTW+PTW-1:0]                i_pifo_pop_data,
  output logic                              o_deq_valid,
  output logic [MTW+PTW-1:0]                o_deq_data,
  input  logic                              i_deq_ready,
  output logic [clog2_cap(CAPACITY)-1:0]    o_occupancy,
  output logic [15:0]                       o_empty_drop_cnt
);

  localparam int EW    = MTW + PTW;
  localparam int OCC_W = clog2_cap(CAPACITY);
  localparam int GAP_W = (OP_GAP > 1) ? $clog2(OP_GAP) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = $clog2(FIFO_DEPTH + POP_LAT + 1);

  localparam logic [EW-1:0]    SENTINEL = '1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(OP_GAP - 1);

  logic [GAP_W-1:0]   gap_cnt;
  logic [OCC_W-1:0]   occ;
  prio_e              prio;
  logic [POP_LAT-1:0] pop_pipe;
  logic [15:0]        drop_cnt;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [EW-1:0]      fifo_rd_data;

  logic [CRD_W-1:0]   inflight;
  logic               credit_ok;
  logic               gap_zero;
  logic               push_ok;
  logic               pop_ok;
  logic               contend;
  logic               pop_issue;
  logic               enq_ready;
  logic               push_issue;
  logic               cap_valid;
  logic               cap_sentinel;
  logic               fifo_wr;

  // Eligibility, round-robin arbitration and pop-result classification.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < POP_LAT; i++) begin
      inflight = inflight + CRD_W'(pop_pipe[i]);
    end
    // Pops still in the tree pipeline already own a buffer slot.
    credit_ok  = (CRD_W'(fifo_count) + inflight) < CRD_W'(FIFO_DEPTH);
    gap_zero   = (gap_cnt == '0);
    push_ok    = !i_rst && gap_zero && (occ < OCC_W'(CAPACITY));
    pop_ok     = !i_rst && gap_zero && (occ != '0) && credit_ok;
    contend    = push_ok && pop_ok && i_enq_valid;
    pop_issue  = pop_ok && (!contend || (prio == PRIO_POP));
    enq_ready  = push_ok && !pop_issue;
    push_issue = i_enq_valid && enq_ready;

    cap_valid    = pop_pipe[POP_LAT-1];
    cap_sentinel = cap_valid && (i_pifo_pop_data == SENTINEL);
    fifo_wr      = cap_valid && !cap_sentinel;
  end

  // Gap timer, occupancy, arbitration pointer, pop pipeline and drop count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gap_cnt  <= '0;
      occ      <= '0;
      prio     <= PRIO_PUSH;
      pop_pipe <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_issue || pop_issue) begin
        gap_cnt <= GAP_LOAD;
      end else if (!gap_zero) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      // An empty answer means our count drifted from the tree; resync to
      // empty but keep a push issued in the same cycle, which the tree holds.
      if (cap_sentinel) begin
        occ <= push_issue ? OCC_W'(1) : '0;
      end else if (push_issue) begin
        occ <= occ + 1'b1;
      end else if (pop_issue) begin
        occ <= occ - 1'b1;
      end

      if (contend) begin
        prio <= pop_issue ? PRIO_PUSH : PRIO_POP;
      end

      pop_pipe[0] <= pop_issue;
      for (int i = 1; i < POP_LAT; i++) begin
        pop_pipe[i] <= pop_pipe[i-1];
      end

      if (cap_sentinel && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  pifo_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_out_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (fifo_wr),
    .i_wr_data (i_pifo_pop_data),
    .i_rd_en   (i_deq_ready),
    .o_empty   (fifo_empty),
    .o_rd_data (fifo_rd_data),
    .o_count   (fifo_count)
  );

  assign o_enq_ready      = enq_ready;
  assign o_pifo_push      = push_issue;
  assign o_pifo_push_data = i_enq_data;
  assign o_pifo_pop       = pop_issue;
  assign o_deq_valid      = !fifo_empty;
  assign o_deq_data       = fifo_rd_data;
  assign o_occupancy      = occ;
  assign o_empty_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_pifo_access_ctrl.sv
// Bench for pifo_access_ctrl: a behavioural PIFO tree and rule-level
// reference model drive and check the controller cycle by cycle.
module tb_pifo_access_ctrl;

  localparam int PTW     = 12;
  localparam int MTW     = 8;
  localparam int EW      = MTW + PTW;
  localparam int CAP     = 14;
  localparam int OP_GAP  = 2;
  localparam int POP_LAT = 1;
  localparam int DEPTH   = 4;
  localparam logic [EW-1:0] SENT = '1;

  logic          i_clk;
  logic          i_rst;
  logic          i_enq_valid;
  logic [EW-1:0] i_enq_data;
  logic          o_enq_ready;
  logic          o_pifo_push;
  logic [EW-1:0] o_pifo_push_data;
  logic          o_pifo_pop;
  logic [EW-1:0] i_pifo_pop_data;
  logic          o_deq_valid;
  logic [EW-1:0] o_deq_data;
  logic          i_deq_ready;
  logic [3:0]    o_occupancy;
  logic [15:0]   o_empty_drop_cnt;

  pifo_access_ctrl #(
    .PTW(PTW), .MTW(MTW), .CAPACITY(CAP), .OP_GAP(OP_GAP),
    .POP_LAT(POP_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_enq_valid      (i_enq_valid),
    .i_enq_data       (i_enq_data),
    .o_enq_ready      (o_enq_ready),
    .o_pifo_push      (o_pifo_push),
    .o_pifo_push_data (o_pifo_push_data),
    .o_pifo_pop       (o_pifo_pop),
    .i_pifo_pop_data  (i_pifo_pop_data),
    .o_deq_valid      (o_deq_valid),
    .o_deq_data       (o_deq_data),
    .i_deq_ready      (i_deq_ready),
    .o_occupancy      (o_occupancy),
    .o_empty_drop_cnt (o_empty_drop_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int            due;
    logic [EW-1:0] data;
  } resp_t;

  int            m_occ, m_gap, m_drop, now;
  bit            m_prio_pop;
  logic [EW-1:0] m_fifo[$];
  resp_t         m_pend[$];
  logic [EW-1:0] m_tree[$];
  logic [EW-1:0] deq_log[$];
  bit            tree_lose;
  bit            saw_push;
  int            n_push, n_pop;

  task automatic model_reset();
    m_occ = 0; m_gap = 0; m_drop = 0; m_prio_pop = 0;
    m_fifo.delete(); m_pend.delete(); m_tree.delete();
  endtask

  // Tree behaviour: smallest rank leaves first, oldest among equal ranks.
  task automatic tree_pop(output logic [EW-1:0] d);
    int best;
    if (m_tree.size() == 0) begin
      d = SENT;
    end else begin
      best = 0;
      for (int i = 1; i < m_tree.size(); i++)
        if (m_tree[i][PTW-1:0] < m_tree[best][PTW-1:0]) best = i;
      d = m_tree[best];
      m_tree.delete(best);
    end
  endtask

  function automatic logic [EW-1:0] rnd_entry();
    logic [MTW-1:0] q;
    logic [PTW-1:0] r;
    q = MTW'($urandom);
    r = PTW'($urandom_range(0, 4094));
    return {q, r};
  endfunction

  // One clock: check the DUT against the rules, advance the model, then
  // present the tree's answer for the next cycle.
  task automatic cycle();
    bit gap_ok, pop_ok, push_base, cont, e_pop, e_ready, e_push, sent, wr;
    resp_t r;
    logic [EW-1:0] d;
    @(negedge i_clk);
    gap_ok    = (m_gap == 0);
    pop_ok    = gap_ok && (m_occ > 0) && ((m_fifo.size() + m_pend.size()) < DEPTH);
    push_base = gap_ok && (m_occ < CAP);
    cont      = pop_ok && push_base && i_enq_valid;
    e_pop     = pop_ok && (!cont || m_prio_pop);
    e_ready   = push_base && !e_pop;
    e_push    = i_enq_valid && e_ready;

    chk_eq("enq_ready", o_enq_ready, e_ready);
    chk_eq("pifo_push", o_pifo_push, e_push);
    chk_eq("pifo_pop", o_pifo_pop, e_pop);
    chk_eq("no_dual_strobe", o_pifo_push & o_pifo_pop, 0);
    chk_eq("occupancy", o_occupancy, m_occ);
    chk_eq("deq_valid", o_deq_valid, m_fifo.size() > 0);
    chk_eq("drop_cnt", o_empty_drop_cnt, m_drop);
    if (e_push) chk_eq("push_data", o_pifo_push_data, i_enq_data);
    if (m_fifo.size() > 0) chk_eq("deq_data", o_deq_data, m_fifo[0]);

    sent = 0; wr = 0; d = '0;
    if (m_pend.size() > 0 && m_pend[0].due == now) begin
      r = m_pend.pop_front();
      if (r.data == SENT) begin
        sent = 1;
        if (m_drop < 65535) m_drop++;
      end else begin
        wr = 1; d = r.data;
      end
    end
    if (m_fifo.size() > 0 && i_deq_ready) deq_log.push_back(m_fifo.pop_front());
    if (wr) m_fifo.push_back(d);
    if (sent) m_occ = e_push ? 1 : 0;
    else      m_occ = m_occ + int'(e_push) - int'(e_pop);
    if (e_push || e_pop) m_gap = OP_GAP - 1;
    else if (m_gap > 0)  m_gap--;
    if (cont) m_prio_pop = !e_pop;
    if (e_push) begin
      n_push++;
      if (!tree_lose) m_tree.push_back(i_enq_data);
    end
    if (e_pop) begin
      n_pop++;
      tree_pop(d);
      r.due = now + POP_LAT; r.data = d;
      m_pend.push_back(r);
    end
    saw_push = e_push;
    now++;
    @(posedge i_clk); #1;
    if (m_pend.size() > 0 && m_pend[0].due == now) i_pifo_pop_data = m_pend[0].data;
    else i_pifo_pop_data = EW'($urandom);
  endtask

  task automatic push_item(input logic [EW-1:0] d);
    i_enq_valid = 1'b1;
    i_enq_data  = d;
    saw_push    = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (saw_push) break;
    end
    chk_eq("push_accept", saw_push, 1);
    i_enq_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    i_enq_valid = 1'b0;
    i_deq_ready = 1'b1;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      done = (m_occ == 0) && (m_fifo.size() == 0) && (m_pend.size() == 0);
      if (done) break;
      cycle();
    end
    chk_eq("drain_done", done, 1);
  endtask

  // Holds reset for n edges (late pop data stays on the bus), checks the
  // reset-time outputs, then releases.
  task automatic apply_reset(input int n);
    i_rst = 1'b1;
    i_enq_valid = 1'b0;
    repeat (n) begin
      @(posedge i_clk); #1;
    end
    @(negedge i_clk);
    chk_eq("rst_enq_ready", o_enq_ready, 0);
    chk_eq("rst_push", o_pifo_push, 0);
    chk_eq("rst_pop", o_pifo_pop, 0);
    chk_eq("rst_deq_valid", o_deq_valid, 0);
    chk_eq("rst_occupancy", o_occupancy, 0);
    chk_eq("rst_drop_cnt", o_empty_drop_cnt, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    int diff;
    i_rst = 1'b1; i_enq_valid = 1'b0; i_enq_data = '0;
    i_deq_ready = 1'b0; i_pifo_pop_data = '0;
    tree_lose = 0; now = 0; n_push = 0; n_pop = 0;
    model_reset();
    apply_reset(3);

    // Idle after reset.
    repeat (10) cycle();

    // Three pushes with the consumer stalled, then drain in rank order.
    i_deq_ready = 1'b0;
    n_pop = 0; deq_log.delete();
    push_item({8'd1, 12'd30});
    push_item({8'd2, 12'd10});
    push_item({8'd3, 12'd20});
    repeat (10) cycle();
    chk_eq("three_pops", n_pop, 3);
    i_deq_ready = 1'b1;
    repeat (6) cycle();
    chk_eq("order_count", deq_log.size(), 3);
    if (deq_log.size() == 3) begin
      chk_eq("order_0", deq_log[0], {8'd2, 12'd10});
      chk_eq("order_1", deq_log[1], {8'd3, 12'd20});
      chk_eq("order_2", deq_log[2], {8'd1, 12'd30});
    end

    // Fill against a stalled consumer: credit limits pops to the buffer depth.
    i_deq_ready = 1'b0;
    n_pop = 0;
    for (int i = 0; i < 14; i++) push_item(rnd_entry());
    repeat (10) cycle();
    chk_eq("fill_occ", o_occupancy, 10);
    chk_eq("fill_pops", n_pop, 4);
    for (int i = 0; i < 4; i++) push_item(rnd_entry());
    repeat (5) cycle();
    chk_eq("full_occ", o_occupancy, 14);
    chk_eq("full_ready", o_enq_ready, 0);
    chk_eq("full_pops", n_pop, 4);
    drain();

    // Continuous enqueue with a ready consumer: slots alternate.
    n_push = 0; n_pop = 0;
    i_deq_ready = 1'b1;
    i_enq_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      i_enq_data = rnd_entry();
      cycle();
    end
    diff = n_push - n_pop;
    chk_eq("rr_balance", (diff >= 0) && (diff <= 2), 1);
    chk_eq("rr_active", n_pop >= 8, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      i_enq_valid = ($urandom_range(0, 3) != 0);
      i_enq_data  = rnd_entry();
      i_deq_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    // Tree loses the entry: the pop comes back empty.
    tree_lose = 1;
    push_item(rnd_entry());
    tree_lose = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_drop == 1) begin found = 1; break; end
    end
    chk_eq("sentinel_seen", found, 1);
    repeat (3) cycle();
    chk_eq("sentinel_drop", o_empty_drop_cnt, 1);
    chk_eq("sentinel_occ", o_occupancy, 0);
    chk_eq("sentinel_noout", o_deq_valid, 0);

    // Reset with a pop in flight and two entries buffered.
    i_deq_ready = 1'b0;
    push_item({8'd7, 12'd5});
    push_item({8'd8, 12'd6});
    push_item({8'd9, 12'd7});
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_fifo.size() == 2 && m_pend.size() == 1) begin found = 1; break; end
      cycle();
    end
    chk_eq("midop_setup", found, 1);
    apply_reset(2);
    repeat (5) cycle();
    chk_eq("post_rst_deq_valid", o_deq_valid, 0);
    chk_eq("post_rst_occ", o_occupancy, 0);

    // A little more random traffic after the mid-operation reset.
    for (int i = 0; i < 100; i++) begin
      i_enq_valid = ($urandom_range(0, 1) != 0);
      i_enq_data  = rnd_entry();
      i_deq_ready = ($urandom_range(0, 1) != 0);
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
